// File: rtl/cordic_prerotate.sv
// cordic_prerotate: input stage of the pipelined CORDIC rotator.
// - Folds a full-circle phase into +-pi/2, loads x0/y0 and the folded z
//   into a 1-cycle data register.
// - Runs a {valid, negate} tag delay line of depth N_STAGES+1. The tags line
//   up with the result at the end of the slice chain.
// Optional feature macro: CORDIC_AMPLITUDE_EN.
//   When it is defined, the block adds an amplitude_i input and sets
//   x0 = (amplitude_i * K_INV) >>> N_FRAC.
module cordic_prerotate #(
  parameter int N_FRAC   = 15,
  parameter int N_STAGES = 14,
  parameter int K_INV    = 19898
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  input  logic signed [N_FRAC:0] phase_i,
`ifdef CORDIC_AMPLITUDE_EN
  input  logic signed [N_FRAC:0] amplitude_i,
`endif
  output logic signed [N_FRAC:0] x_o,
  output logic signed [N_FRAC:0] y_o,
  output logic signed [N_FRAC:0] z_o,
  output logic                tag_valid_o,
  output logic                tag_negate_o
);

  localparam logic signed [N_FRAC:0] H_POS = (N_FRAC+1)'(2**(N_FRAC-1));
  localparam logic signed [N_FRAC:0] H_NEG = -H_POS;
  localparam logic signed [N_FRAC:0] PI_W  = {1'b1, {N_FRAC{1'b0}}};
  localparam logic signed [N_FRAC:0] K_W   = (N_FRAC+1)'(K_INV);

  typedef struct packed {
    logic valid;
    logic neg;
  } tag_t;

  logic signed [N_FRAC:0] z_fold, x_start;
  logic                   neg;
  logic signed [N_FRAC:0] x_d, x_q, y_d, y_q, z_d, z_q;
  tag_t [N_STAGES:0]      tag_d, tag_q;

`ifdef CORDIC_AMPLITUDE_EN
  // A 31-bit product is wide enough because K_INV is positive, so the
  // -2^N_FRAC * -2^N_FRAC corner case cannot occur.
  logic signed [2*N_FRAC:0] amp_prod;
`endif

  // Fold the phase into +-pi/2 and choose the start x.
  // Adding pi wraps on purpose: phase - pi and phase + pi are the same word.
  always_comb begin
    neg    = !((phase_i >= H_NEG) && (phase_i <= H_POS));
    z_fold = neg ? (phase_i + PI_W) : phase_i;
`ifdef CORDIC_AMPLITUDE_EN
    amp_prod = amplitude_i * K_W;
    x_start  = amp_prod[2*N_FRAC:N_FRAC];
`else
    x_start  = K_W;
`endif
  end

  // Next-state logic.
  // The data register loads only on valid_i and otherwise holds its value.
  // The tag line shifts on every clock.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    if (valid_i) begin
      x_d = x_start;
      y_d = '0;
      z_d = z_fold;
    end
    tag_d[0].valid = valid_i;
    tag_d[0].neg   = neg & valid_i;
    for (int i = 1; i <= N_STAGES; i++) tag_d[i] = tag_q[i-1];
  end

  // State registers.
  // Reset also clears the whole tag line, so no in-flight sample survives it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      tag_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      z_q   <= z_d;
      tag_q <= tag_d;
    end
  end

  assign x_o          = x_q;
  assign y_o          = y_q;
  assign z_o          = z_q;
  assign tag_valid_o  = tag_q[N_STAGES].valid;
  assign tag_negate_o = tag_q[N_STAGES].neg;

endmodule
